// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central pipeline controller for the 5-stage core. It resolves load-use
//   hazards, instruction-fetch misses, data-memory stalls and taken redirects
//   into PC / IF/ID / ID/EX enable and flush controls. A small FSM plus a
//   down-counter stretches the IF/ID flush over FLUSH_CYCLES cycles after a
//   taken redirect.
//
// Parameters
//   FLUSH_CYCLES  cycles if_id_flush is held after a taken redirect (1..7)
//   REG_ADDR_W    register index width
//
// Ports
//   clk, reset            core clock, synchronous active-high reset
//   id_rs1/id_rs2         ID-stage source registers
//   id_rs1_used/_rs2_used ID instruction actually reads rs1/rs2
//   ex_rd, ex_mem_read    EX destination register, EX is a load
//   ex_redirect           EX resolved a taken branch/jump
//   imem_ready            fetch data valid this cycle
//   dmem_busy             data memory stalls MEM stage
//   pc_write, pc_redirect PC update enable, select EX target as next PC
//   if_id_valid/_flush    IF/ID capture enable / clear
//   id_ex_flush           ID/EX clear (bubble insert)
//   ctrl_state            current FSM state (0 RUN, 1 REDIRECT, 2 MEM_WAIT)
//
// Optional feature (macro PIPE_PERF_CNT_EN)
//   Adds 32-bit wrapping counters stall_cnt (cycles with pc_write=0),
//   flush_cnt (redirects accepted in RUN) and lu_cnt (load-use stall cycles).
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  imem_ready,
    input  logic                  dmem_busy,
    output logic                  pc_write,
    output logic                  pc_redirect,
    output logic                  if_id_valid,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [1:0]            ctrl_state
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt,
    output logic [31:0]           lu_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_e;

    // Cycles spent in REDIRECT after the RUN cycle that accepted the redirect.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic load_use;
    logic redirect_taken;   // redirect accepted in RUN this cycle
    logic lu_stall;         // load-use bubble inserted this cycle

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    always_comb begin
        load_use = ex_mem_read && (ex_rd != '0) &&
                   ((id_rs1_used && (id_rs1 == ex_rd)) ||
                    (id_rs2_used && (id_rs2 == ex_rd)));
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_write       = 1'b0;
        pc_redirect    = 1'b0;
        if_id_valid    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        redirect_taken = 1'b0;
        lu_stall       = 1'b0;

        // While reset is high the controls stay at 0; the flops clear below.
        if (!reset) begin
            unique case (state_q)
                ST_RUN: begin
                    if (dmem_busy) begin
                        // Freeze everything; a pending redirect stays held in EX.
                        state_d = ST_MEM_WAIT;
                    end else if (ex_redirect) begin
                        // ID holds a wrong-path instruction, so any load-use
                        // match against it is irrelevant.
                        pc_write       = 1'b1;
                        pc_redirect    = 1'b1;
                        if_id_flush    = 1'b1;
                        id_ex_flush    = 1'b1;
                        redirect_taken = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            cnt_d   = FLUSH_LOAD;
                            state_d = ST_REDIRECT;
                        end
                    end else if (load_use) begin
                        // One bubble suffices: the load moves on to MEM.
                        id_ex_flush = 1'b1;
                        lu_stall    = 1'b1;
                    end else if (!imem_ready) begin
                        if_id_flush = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_valid = 1'b1;
                    end
                end

                ST_REDIRECT: begin
                    pc_write    = imem_ready;
                    if_id_flush = 1'b1;
                    cnt_d       = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end

                ST_MEM_WAIT: begin
                    if (!dmem_busy) begin
                        state_d = ST_RUN;
                    end
                end

                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    assign ctrl_state = reset ? ST_RUN : state_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] lu_cnt_q,    lu_cnt_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        lu_cnt_d    = lu_cnt_q;
        if (!pc_write)      stall_cnt_d = stall_cnt_q + 32'd1;
        if (redirect_taken) flush_cnt_d = flush_cnt_q + 32'd1;
        if (lu_stall)       lu_cnt_d    = lu_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign lu_cnt    = lu_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl. Directed scenarios compare the
//   control vector against hand-derived constants; a randomized run compares
//   against a behavioural model that tracks "cycles of flush left" and
//   "waiting on memory" as plain integers and applies the priority rules.
//   Control vector layout: {pc_write, pc_redirect, if_id_valid, if_id_flush,
//   id_ex_flush, ctrl_state[1:0]}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int FC = 2;
    localparam int AW = 5;

    localparam logic [6:0] V_ZERO  = 7'b0_0_0_0_0_00;
    localparam logic [6:0] V_NORM  = 7'b1_0_1_0_0_00;
    localparam logic [6:0] V_LU    = 7'b0_0_0_0_1_00;
    localparam logic [6:0] V_IMISS = 7'b0_0_0_1_0_00;
    localparam logic [6:0] V_RDR   = 7'b1_1_0_1_1_00;
    localparam logic [6:0] V_FL    = 7'b1_0_0_1_0_01;
    localparam logic [6:0] V_FL_NR = 7'b0_0_0_1_0_01;
    localparam logic [6:0] V_WAIT  = 7'b0_0_0_0_0_10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic          ex_mem_read = 1'b0, ex_redirect = 1'b0;
    logic          imem_ready = 1'b1, dmem_busy = 1'b0;

    logic       pc_write, pc_redirect, if_id_valid, if_id_flush, id_ex_flush;
    logic [1:0] ctrl_state;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, lu_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_redirect (ex_redirect),
        .imem_ready  (imem_ready),
        .dmem_busy   (dmem_busy),
        .pc_write    (pc_write),
        .pc_redirect (pc_redirect),
        .if_id_valid (if_id_valid),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .ctrl_state  (ctrl_state)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .lu_cnt      (lu_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [6:0] obs;
    assign obs = {pc_write, pc_redirect, if_id_valid, if_id_flush, id_ex_flush, ctrl_state};

    // ---------------- behavioural reference model ----------------
    int          m_flush_left = 0;   // REDIRECT cycles still to come
    bit          m_waiting    = 1'b0;
    logic [31:0] m_stall = '0, m_flush = '0, m_lu = '0;

    function automatic bit spec_lu();
        return ex_mem_read && (ex_rd != 0) &&
               ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    endfunction

    function automatic logic [6:0] model_vec();
        logic pw, pr, iv, ifl, ief;
        logic [1:0] st;
        {pw, pr, iv, ifl, ief} = 5'b0;
        st = 2'd0;
        if (reset) begin
        end else if (m_waiting) begin
            st = 2'd2;
        end else if (m_flush_left > 0) begin
            st  = 2'd1;
            pw  = imem_ready;
            ifl = 1'b1;
        end else if (dmem_busy) begin
        end else if (ex_redirect) begin
            {pw, pr, ifl, ief} = 4'b1111;
        end else if (spec_lu()) begin
            ief = 1'b1;
        end else if (!imem_ready) begin
            ifl = 1'b1;
        end else begin
            {pw, iv} = 2'b11;
        end
        return {pw, pr, iv, ifl, ief, st};
    endfunction

    always @(posedge clk) begin : model_update
        logic [6:0] e;
        e = model_vec();
        if (reset) begin
            m_flush_left = 0;
            m_waiting    = 1'b0;
            m_stall      = '0;
            m_flush      = '0;
            m_lu         = '0;
        end else begin
            if (!e[6]) m_stall = m_stall + 32'd1;
            if (m_waiting) begin
                m_waiting = dmem_busy;
            end else if (m_flush_left > 0) begin
                m_flush_left = m_flush_left - 1;
            end else if (dmem_busy) begin
                m_waiting = 1'b1;
            end else if (ex_redirect) begin
                m_flush      = m_flush + 32'd1;
                m_flush_left = FC - 1;
            end else if (spec_lu()) begin
                m_lu = m_lu + 32'd1;
            end
        end
    end

    // A flushed EX cannot hold a branch, so the stimulus must never drive one.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(ctrl_state == 2'd1 && ex_redirect))
                else $error("ex_redirect driven while in REDIRECT");
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_mem_read = 1'b0; ex_redirect = 1'b0;
        imem_ready = 1'b1; dmem_busy = 1'b0;
    endtask

    task automatic set_lu(input logic [AW-1:0] r);
        ex_mem_read = 1'b1; ex_rd = r; id_rs1 = r; id_rs1_used = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        ex_redirect = 1'b1;
        set_lu(5'd3);
        for (int i = 0; i < 3; i++) begin
            #4;
            if (obs !== V_ZERO) begin
                errors++;
                $display("FAIL reset[%0d]: got %b want %b", i, obs, V_ZERO);
            end
            checks++;
            next_cycle();
        end
`ifdef PIPE_PERF_CNT_EN
        if ({stall_cnt, flush_cnt, lu_cnt} !== 96'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, lu_cnt);
        end
        checks++;
`endif
        set_idle();
        reset = 1'b0;
    endtask

    task automatic test_normal();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            #4;
            if (obs !== V_NORM) begin
                errors++;
                $display("FAIL normal[%0d]: got %b want %b", i, obs, V_NORM);
            end
            checks++;
            next_cycle();
        end
    endtask

    typedef struct packed {
        logic          mr;
        logic [AW-1:0] rd, rs1, rs2;
        logic          u1, u2;
        logic [6:0]    exp;
    } lu_case_t;

    task automatic test_load_use();
        lu_case_t cases [6];
        cases = '{
            '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, V_LU},
            '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, V_NORM},
            '{1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, V_LU},
            '{1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b1, V_NORM},
            '{1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, V_NORM},
            '{1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, V_NORM}
        };
        for (int i = 0; i < 6; i++) begin
            set_idle();
            ex_mem_read = cases[i].mr; ex_rd = cases[i].rd;
            id_rs1 = cases[i].rs1; id_rs2 = cases[i].rs2;
            id_rs1_used = cases[i].u1; id_rs2_used = cases[i].u2;
            #4;
            if (obs !== cases[i].exp) begin
                errors++;
                $display("FAIL load_use[%0d]: got %b want %b", i, obs, cases[i].exp);
            end
            checks++;
            next_cycle();
            set_idle();
            #4;
            if (obs !== V_NORM) begin
                errors++;
                $display("FAIL load_use_after[%0d]: got %b want %b", i, obs, V_NORM);
            end
            checks++;
            next_cycle();
        end
    endtask

    task automatic test_redirect();
        logic [6:0] exp [6];
        logic       rdy [6];
        logic       rdr [6];
        exp = '{V_RDR, V_FL, V_NORM, V_RDR, V_FL_NR, V_NORM};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        rdr = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        set_idle();
        for (int i = 0; i < 6; i++) begin
            ex_redirect = rdr[i];
            imem_ready  = rdy[i];
            #4;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL redirect[%0d]: got %b want %b", i, obs, exp[i]);
            end
            checks++;
            next_cycle();
        end
    endtask

    task automatic test_redirect_lu();
        set_idle();
        ex_redirect = 1'b1;
        set_lu(5'd6);
        #4;
        if (obs !== V_RDR) begin
            errors++;
            $display("FAIL redirect_lu: got %b want %b", obs, V_RDR);
        end
        checks++;
        next_cycle();
        ex_redirect = 1'b0;   // load-use inputs still present but ignored in REDIRECT
        #4;
        if (obs !== V_FL) begin
            errors++;
            $display("FAIL redirect_lu_flush: got %b want %b", obs, V_FL);
        end
        checks++;
        next_cycle();
        set_idle();
`ifdef PIPE_PERF_CNT_EN
        if (lu_cnt !== m_lu || flush_cnt !== m_flush) begin
            errors++;
            $display("FAIL redirect_lu_cnt: got lu=%0d fl=%0d want lu=%0d fl=%0d",
                     lu_cnt, flush_cnt, m_lu, m_flush);
        end
        checks++;
`endif
    endtask

    task automatic test_mem_wait();
        logic [6:0] exp  [7];
        logic       busy [7];
        logic       rdr  [7];
        exp  = '{V_ZERO, V_WAIT, V_WAIT, V_WAIT, V_RDR, V_FL, V_NORM};
        busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        rdr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        set_idle();
        for (int i = 0; i < 7; i++) begin
            dmem_busy   = busy[i];
            ex_redirect = rdr[i];
            #4;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL mem_wait[%0d]: got %b want %b", i, obs, exp[i]);
            end
            checks++;
            next_cycle();
        end
    endtask

    task automatic test_imem_stall();
        logic [6:0] exp [4];
        logic       rdy [4];
        logic       lu  [4];
        exp = '{V_IMISS, V_IMISS, V_LU, V_NORM};
        rdy = '{1'b0, 1'b0, 1'b0, 1'b1};
        lu  = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            set_idle();
            imem_ready = rdy[i];
            if (lu[i]) set_lu(5'd12);
            #4;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL imem_stall[%0d]: got %b want %b", i, obs, exp[i]);
            end
            checks++;
            next_cycle();
        end
        set_idle();
    endtask

    task automatic test_reset_abort();
        logic [6:0] exp  [7];
        logic       rst  [7];
        logic       rdr  [7];
        logic       busy [7];
        // Redirect then reset in REDIRECT; MEM_WAIT then reset while busy.
        exp  = '{V_RDR, V_ZERO, V_NORM, V_ZERO, V_WAIT, V_ZERO, V_NORM};
        rst  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rdr  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        busy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        set_idle();
        for (int i = 0; i < 7; i++) begin
            reset       = rst[i];
            ex_redirect = rdr[i];
            dmem_busy   = busy[i];
            #4;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL reset_abort[%0d]: got %b want %b", i, obs, exp[i]);
            end
            checks++;
            next_cycle();
        end
        reset = 1'b0;
        set_idle();
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_perf_cnt();
        reset = 1'b1;
        set_idle();
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_lu(5'd4);
            next_cycle();
            set_idle();
            next_cycle();
        end
        if (lu_cnt !== 32'd4 || stall_cnt !== 32'd4 || flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_cnt: got st=%0d fl=%0d lu=%0d want 4/0/4",
                     stall_cnt, flush_cnt, lu_cnt);
        end
        checks++;
        reset = 1'b1;
        next_cycle();
        if ({stall_cnt, flush_cnt, lu_cnt} !== 96'd0) begin
            errors++;
            $display("FAIL perf_cnt_clear: got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, lu_cnt);
        end
        checks++;
        reset = 1'b0;
    endtask
`endif

    task automatic test_random();
        reset = 1'b1;
        set_idle();
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(99, 0) == 0);
            dmem_busy   = ($urandom_range(5, 0) == 0);
            imem_ready  = ($urandom_range(4, 0) != 0);
            ex_redirect = (!m_waiting && m_flush_left > 0) ? 1'b0 : ($urandom_range(7, 0) == 0);
            ex_mem_read = ($urandom_range(2, 0) == 0);
            ex_rd       = AW'($urandom_range(3, 0));
            id_rs1      = AW'($urandom_range(3, 0));
            id_rs2      = AW'($urandom_range(3, 0));
            id_rs1_used = 1'($urandom_range(1, 0));
            id_rs2_used = 1'($urandom_range(1, 0));
            #4;
            if (obs !== model_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %b want %b", i, obs, model_vec());
            end
            checks++;
            next_cycle();
        end
        reset = 1'b0;
        set_idle();
`ifdef PIPE_PERF_CNT_EN
        if (stall_cnt !== m_stall || flush_cnt !== m_flush || lu_cnt !== m_lu) begin
            errors++;
            $display("FAIL random_cnt: got %0d/%0d/%0d want %0d/%0d/%0d",
                     stall_cnt, flush_cnt, lu_cnt, m_stall, m_flush, m_lu);
        end
        checks++;
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_normal();
        test_load_use();
        test_redirect();
        test_redirect_lu();
        test_mem_wait();
        test_imem_stall();
        test_reset_abort();
`ifdef PIPE_PERF_CNT_EN
        test_perf_cnt();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Watches ID operands, the EX-stage load and branch status, instruction-memory readiness and data-memory busy.
- Generates the enable and flush controls for PC, IF/ID and ID/EX: PC write, IF/ID valid/flush, ID/EX flush.
- Sequences multi-cycle redirect flushes with a small FSM and counter.

Parameters:
- FLUSH_CYCLES, 2, total cycles if_id_flush is held after a taken redirect (min 1, max 7).
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- id_rs1  in  REG_ADDR_W  ID-stage source register 1
- id_rs2  in  REG_ADDR_W  ID-stage source register 2
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_rd  in  REG_ADDR_W  EX-stage destination register
- ex_mem_read  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved a taken branch or jump
- imem_ready  in  1  fetch data valid this cycle
- dmem_busy  in  1  data memory stalls MEM stage
- pc_write  out  1  PC register update enable
- pc_redirect  out  1  select EX target as next PC
- if_id_valid  out  1  IF/ID capture enable
- if_id_flush  out  1  IF/ID clear
- id_ex_flush  out  1  ID/EX clear (bubble insert)
- ctrl_state  out  2  current FSM state, for debug

Behaviour:
- Reset is synchronous; clk/reset names as used throughout the core.
- While reset=1:
  - all outputs drive 0 except ctrl_state=RUN (2'd0);
  - the redirect counter clears to 0.
- Reset asserted mid-REDIRECT or mid-MEM_WAIT aborts the operation; the next state is RUN.
- FSM states:
  - RUN = 0
  - REDIRECT = 1
  - MEM_WAIT = 2
  - 3 is unused and recovers to RUN next cycle with all outputs 0.
- Outputs are combinational from state and inputs (Mealy), so flushes act in the same cycle the cause is seen.
- Load-use hazard: lu = ex_mem_read & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)).
- Priority within RUN, highest first:
  1. dmem_busy
  2. ex_redirect
  3. lu
  4. !imem_ready
  5. normal
- RUN, dmem_busy=1:
  - pc_write=0, if_id_valid=0, no flushes;
  - next state MEM_WAIT.
  - A pending ex_redirect stays held by EX and is acted on after the stall.
- RUN, ex_redirect=1:
  - pc_write=1, pc_redirect=1, if_id_flush=1, id_ex_flush=1.
  - If FLUSH_CYCLES>1: load counter with FLUSH_CYCLES-1; next state REDIRECT.
  - A simultaneous lu is ignored, because the ID instruction is wrong-path.
- RUN, lu=1:
  - pc_write=0, if_id_valid=0, id_ex_flush=1 for exactly one cycle (the load advances, so the hazard clears);
  - stay in RUN.
- RUN, imem_ready=0:
  - pc_write=0, if_id_flush=1 (bubble enters ID), if_id_valid=0;
  - stay in RUN.
- RUN, normal: pc_write=1, if_id_valid=1, all flushes 0.
- REDIRECT:
  - pc_write=imem_ready, if_id_flush=1, if_id_valid=0, id_ex_flush=0, pc_redirect=0;
  - counter decrements each cycle; at count reaching 0, next state is RUN.
  - A new ex_redirect in REDIRECT is impossible because the flushed EX holds no branch; the bench asserts this.
- MEM_WAIT:
  - same outputs as the RUN dmem_busy case;
  - when dmem_busy=0, next state RUN and RUN priority applies from the following cycle.
- if_id_flush and if_id_valid are never both 1.
- pc_redirect=1 implies pc_write=1.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined, the block adds these outputs:
  - stall_cnt[31:0]: counts cycles with pc_write=0.
  - flush_cnt[31:0]: counts cycles with ex_redirect accepted in RUN.
  - lu_cnt[31:0]: counts lu stall cycles.
- Counter rules:
  - all three clear on reset;
  - each wraps at 2^32 to 0.
- When the macro is undefined, these ports and registers are absent, and the remaining behaviour is identical.

Test Plan:
- Reset released, imem_ready=1, no hazards -> pc_write=1, if_id_valid=1, flushes 0, ctrl_state=0 every cycle.
- ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1, one cycle -> pc_write=0, if_id_valid=0, id_ex_flush=1 that cycle; normal next cycle. Repeat with ex_rd=0 -> no stall.
- ex_redirect pulse with FLUSH_CYCLES=2 -> cycle 0: pc_redirect=1, if_id_flush=1, id_ex_flush=1. Cycle 1: state 1, if_id_flush=1. Cycle 2: state 0, normal.
- ex_redirect and load-use hazard in the same cycle -> redirect response only, id_ex_flush=1, no lu stall counted.
- dmem_busy=1 for 3 cycles with ex_redirect=1 held -> 3 cycles in MEM_WAIT with everything frozen, then redirect flush on cycle 4.
- reset asserted in REDIRECT cycle 1 -> next cycle state 0, outputs 0. With PIPE_PERF_CNT_EN, after 4 lu stalls lu_cnt=4, and reset clears it to 0.
